// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store bridge from pipeline requests to a word-wide data bus
module load_store_unit #(
  parameter int ADDR_SIZE      = 32,
  parameter int WORD_LEN       = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWrite,
  input  logic [2:0]           reqFunct3,
  input  logic [ADDR_SIZE-1:0] reqAddr,
  input  logic [WORD_LEN-1:0]  reqWData,
  output logic                 rspValid,
  input  logic                 rspReady,
  output logic [WORD_LEN-1:0]  rspData,
  output logic [1:0]           rspErr,
  output logic                 memReq,
  output logic                 memWe,
  output logic [ADDR_SIZE-1:0] memAddr,
  output logic [3:0]           memBe,
  output logic [WORD_LEN-1:0]  memWData,
  input  logic                 memAck,
  input  logic [WORD_LEN-1:0]  memRData
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t                 state_q;
  logic                   we_q;
  logic [2:0]             f3_q;
  logic [ADDR_SIZE-1:0]   addr_q;
  logic [WORD_LEN-1:0]    wdata_q;
  logic [CW-1:0]          cnt_q;
  logic [WORD_LEN-1:0]    rdata_q;
  logic [1:0]             err_q;
  logic                   bus, illegal, misaligned;
  logic [1:0]             off;
  logic [7:0]             ld_b;
  logic [15:0]            ld_h;
  logic [3:0]             be;
  logic [WORD_LEN-1:0]    wd, ld;
  assign bus        = state_q == BUS;
  assign off        = addr_q[1:0];
  assign illegal    = reqFunct3 == 3'b011 || reqFunct3[2:1] == 2'b11;
  assign misaligned = (reqFunct3[1:0] == 2'b01 && reqAddr[0]) || (reqFunct3 == 3'b010 && reqAddr[1:0] != 2'b00);
  // Lane shift selects the addressed byte/half; halves are aligned so off is 0 or 2
  assign ld_b = 8'(memRData >> {off, 3'b000});
  assign ld_h = 16'(memRData >> {off, 3'b000});
  assign ld = f3_q == 3'b000 ? {{(WORD_LEN-8){ld_b[7]}}, ld_b} :
              f3_q == 3'b001 ? {{(WORD_LEN-16){ld_h[15]}}, ld_h} :
              f3_q == 3'b100 ? {{(WORD_LEN-8){1'b0}}, ld_b} :
              f3_q == 3'b101 ? {{(WORD_LEN-16){1'b0}}, ld_h} : memRData;
  assign be = f3_q[1:0] == 2'b00 ? 4'b0001 << off : f3_q[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
  assign wd = f3_q[1:0] == 2'b00 ? {4{wdata_q[7:0]}} : f3_q[1:0] == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
  assign reqReady = rstn && state_q == IDLE;
  assign rspValid = state_q == RESP;
  assign rspData  = rdata_q;
  assign rspErr   = err_q;
  assign memReq   = bus;
  assign memWe    = bus && we_q;
  assign memAddr  = bus ? {addr_q[ADDR_SIZE-1:2], 2'b00} : '0;
  assign memBe    = bus ? be : 4'b0000;
  assign memWData = bus ? wd : '0;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 2'b00;
    end else begin
      case (state_q)
        IDLE: if (reqValid) begin
          we_q    <= reqWrite;
          f3_q    <= reqFunct3;
          addr_q  <= reqAddr;
          wdata_q <= reqWData;
          cnt_q   <= '0;
          rdata_q <= '0;
          err_q   <= illegal ? 2'b11 : misaligned ? 2'b01 : 2'b00;
          state_q <= illegal || misaligned ? RESP : BUS;
        end
        BUS: if (memAck) begin
          rdata_q <= we_q ? '0 : ld;
          err_q   <= 2'b00;
          state_q <= RESP;
        end else if (cnt_q == LAST) begin
          err_q   <= 2'b10;
          state_q <= RESP;
        end else cnt_q <= cnt_q + 1'b1;
        RESP: if (rspReady) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed self-checking bench for load_store_unit
module tb_load_store_unit;
  localparam int T = 16;
  logic clk = 1'b0, rstn = 1'b0;
  logic reqValid = 1'b0, reqReady, reqWrite = 1'b0;
  logic [2:0] reqFunct3 = 3'b000;
  logic [31:0] reqAddr = '0, reqWData = '0;
  logic rspValid, rspReady = 1'b1;
  logic [31:0] rspData;
  logic [1:0] rspErr;
  logic memReq, memWe, memAck = 1'b0;
  logic [31:0] memAddr, memWData, memRData = '0;
  logic [3:0] memBe;
  int n_vec = 0, n_bad = 0;
  always #5 clk = ~clk;
  load_store_unit #(.ADDR_SIZE(32), .WORD_LEN(32), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rstn(rstn), .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqFunct3(reqFunct3), .reqAddr(reqAddr), .reqWData(reqWData), .rspValid(rspValid),
    .rspReady(rspReady), .rspData(rspData), .rspErr(rspErr), .memReq(memReq), .memWe(memWe),
    .memAddr(memAddr), .memBe(memBe), .memWData(memWData), .memAck(memAck), .memRData(memRData));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    reqWrite = we; reqFunct3 = f3; reqAddr = a; reqWData = wd; reqValid = 1'b1;
    tick();
    reqValid = 1'b0;
  endtask
  task automatic test_reset;
    #2;
    n_vec++; if (reqReady !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b want 0", reqReady); end
    n_vec++; if (memReq !== 1'b0) begin n_bad++; $display("FAIL reset_memreq got %b want 0", memReq); end
    n_vec++; if (rspValid !== 1'b0 || rspErr !== 2'b00 || rspData !== 32'h0) begin n_bad++; $display("FAIL reset_rsp got v=%b e=%b d=%h want 0", rspValid, rspErr, rspData); end
    tick(); tick();
    #2 rstn = 1'b1;
    #1;
    n_vec++; if (reqReady !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready got %b want 1", reqReady); end
    tick();
  endtask
  task automatic test_load_byte;
    memRData = 32'h80FF_1234; memAck = 1'b1;
    issue(1'b0, 3'b100, 32'h103, 32'h0);
    n_vec++; if (memReq !== 1'b1 || memWe !== 1'b0) begin n_bad++; $display("FAIL lbu_req got req=%b we=%b want 1/0", memReq, memWe); end
    n_vec++; if (memAddr !== 32'h100) begin n_bad++; $display("FAIL lbu_addr got %h want 00000100", memAddr); end
    n_vec++; if (memBe !== 4'b1000) begin n_bad++; $display("FAIL lbu_be got %b want 1000", memBe); end
    tick();
    n_vec++; if (rspValid !== 1'b1 || memReq !== 1'b0) begin n_bad++; $display("FAIL lbu_valid got v=%b req=%b want 1/0", rspValid, memReq); end
    n_vec++; if (rspData !== 32'h0000_0080 || rspErr !== 2'b00) begin n_bad++; $display("FAIL lbu_data got %h/%b want 00000080/00", rspData, rspErr); end
    tick();
    n_vec++; if (rspValid !== 1'b0 || reqReady !== 1'b1) begin n_bad++; $display("FAIL lbu_idle got v=%b rdy=%b want 0/1", rspValid, reqReady); end
    memAck = 1'b0;
  endtask
  task automatic test_load_ext;
    logic [2:0]  f3 [4] = '{3'b001, 3'b101, 3'b000, 3'b010};
    logic [31:0] ad [4] = '{32'h202, 32'h206, 32'h101, 32'h600};
    logic [31:0] rd [4] = '{32'h8001_0000, 32'hBEEF_0000, 32'h0000_8000, 32'hCAFE_F00D};
    logic [3:0]  eb [4] = '{4'b1100, 4'b1100, 4'b0010, 4'b1111};
    logic [31:0] ed [4] = '{32'hFFFF_8001, 32'h0000_BEEF, 32'hFFFF_FF80, 32'hCAFE_F00D};
    for (int i = 0; i < 4; i++) begin
      memRData = rd[i];
      issue(1'b0, f3[i], ad[i], 32'h0);
      memAck = 1'b1;
      n_vec++; if (memBe !== eb[i]) begin n_bad++; $display("FAIL ld%0d_be got %b want %b", i, memBe, eb[i]); end
      tick();
      memAck = 1'b0;
      n_vec++; if (rspValid !== 1'b1 || rspData !== ed[i] || rspErr !== 2'b00) begin n_bad++; $display("FAIL ld%0d_rsp got v=%b d=%h e=%b want 1/%h/00", i, rspValid, rspData, rspErr, ed[i]); end
      tick();
    end
  endtask
  task automatic test_store_byte;
    memRData = 32'h1111_2222;
    issue(1'b1, 3'b000, 32'h301, 32'h0000_00AB);
    memAck = 1'b1;
    n_vec++; if (memWe !== 1'b1 || memBe !== 4'b0010) begin n_bad++; $display("FAIL sb_we_be got we=%b be=%b want 1/0010", memWe, memBe); end
    n_vec++; if (memWData !== 32'hABAB_ABAB || memAddr !== 32'h300) begin n_bad++; $display("FAIL sb_wdata got %h@%h want ABABABAB@00000300", memWData, memAddr); end
    tick();
    memAck = 1'b0;
    n_vec++; if (rspValid !== 1'b1 || rspData !== 32'h0 || rspErr !== 2'b00) begin n_bad++; $display("FAIL sb_rsp got v=%b d=%h e=%b want 1/0/00", rspValid, rspData, rspErr); end
    tick();
  endtask
  task automatic test_errors;
    logic [2:0]  f3 [3] = '{3'b010, 3'b011, 3'b101};
    logic [31:0] ad [3] = '{32'h402, 32'h401, 32'h201};
    logic [1:0]  ee [3] = '{2'b01, 2'b11, 2'b01};
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, f3[i], ad[i], 32'h0);
      n_vec++; if (memReq !== 1'b0) begin n_bad++; $display("FAIL err%0d_memreq got %b want 0", i, memReq); end
      n_vec++; if (rspValid !== 1'b1 || rspErr !== ee[i] || rspData !== 32'h0) begin n_bad++; $display("FAIL err%0d_rsp got v=%b e=%b d=%h want 1/%b/0", i, rspValid, rspErr, rspData, ee[i]); end
      tick();
    end
  endtask
  task automatic test_timeout;
    int n = 0;
    rspReady = 1'b0;
    issue(1'b0, 3'b010, 32'h500, 32'h0);
    while (memReq === 1'b1 && n < T + 5) begin n++; tick(); end
    n_vec++; if (n !== T) begin n_bad++; $display("FAIL to_cycles got %0d want %0d", n, T); end
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (rspValid !== 1'b1 || rspErr !== 2'b10 || rspData !== 32'h0) begin n_bad++; $display("FAIL to_hold%0d got v=%b e=%b d=%h want 1/10/0", i, rspValid, rspErr, rspData); end
      tick();
    end
    rspReady = 1'b1;
    tick();
    n_vec++; if (rspValid !== 1'b0 || reqReady !== 1'b1) begin n_bad++; $display("FAIL to_release got v=%b rdy=%b want 0/1", rspValid, reqReady); end
  endtask
  task automatic test_ack_at_limit;
    memRData = 32'h1234_5678;
    issue(1'b0, 3'b010, 32'h600, 32'h0);
    for (int i = 0; i < T - 1; i++) tick();
    memAck = 1'b1;
    n_vec++; if (memReq !== 1'b1) begin n_bad++; $display("FAIL lim_memreq got %b want 1", memReq); end
    tick();
    memAck = 1'b0;
    n_vec++; if (rspValid !== 1'b1 || rspErr !== 2'b00 || rspData !== 32'h1234_5678) begin n_bad++; $display("FAIL lim_rsp got v=%b e=%b d=%h want 1/00/12345678", rspValid, rspErr, rspData); end
    tick();
  endtask
  task automatic test_reset_mid_bus;
    issue(1'b0, 3'b010, 32'h700, 32'h0);
    n_vec++; if (memReq !== 1'b1) begin n_bad++; $display("FAIL rst_pre_memreq got %b want 1", memReq); end
    rstn = 1'b0;
    #1;
    n_vec++; if (memReq !== 1'b0 || reqReady !== 1'b0 || rspValid !== 1'b0) begin n_bad++; $display("FAIL rst_async got req=%b rdy=%b v=%b want 0/0/0", memReq, reqReady, rspValid); end
    #1 rstn = 1'b1;
    #1;
    n_vec++; if (reqReady !== 1'b1) begin n_bad++; $display("FAIL rst_ready got %b want 1", reqReady); end
    tick();
    n_vec++; if (rspValid !== 1'b0 || memReq !== 1'b0) begin n_bad++; $display("FAIL rst_no_rsp got v=%b req=%b want 0/0", rspValid, memReq); end
  endtask
  initial begin
    test_reset();
    test_load_byte();
    test_load_ext();
    test_store_byte();
    test_errors();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid_bus();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
